// File: rtl/register_file.sv
// Register file with power-up clear sweep, dual combinational reads and per-register pending (scoreboard) bits.
// Optional same-cycle write-to-read forwarding when REGISTER_FILE_BYPASS_EN is defined.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              claimValid,
  input  logic [ADDR_W-1:0] claimReg,
  output logic              pending1,
  output logic              pending2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic run, wr_en, claim_en;

  assign run      = (state_q == ST_RUN);
  assign wr_en    = run && regWrite && !(ZR && writeReg == '0);
  assign claim_en = run && claimValid && !(ZR && claimReg == '0);
  assign ready    = run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) state_d = ST_RUN;
    end
  end

  // Claim is applied after the clear so a same-cycle claim on the written index wins.
  always_comb begin
    pend_d = pend_q;
    if (run && regWrite) pend_d[writeReg] = 1'b0;
    if (claim_en)        pend_d[claimReg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage is not reset; the INIT sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!run)       regs_q[cnt_q]    <= '0;
    else if (wr_en) regs_q[writeReg] <= writeData;
  end

  always_comb begin
    readData1 = '0;
    readData2 = '0;
    pending1  = 1'b0;
    pending2  = 1'b0;
    if (run) begin
      readData1 = (ZR && readReg1 == '0) ? '0 : regs_q[readReg1];
      readData2 = (ZR && readReg2 == '0) ? '0 : regs_q[readReg2];
      pending1  = pend_q[readReg1];
      pending2  = pend_q[readReg2];
`ifdef REGISTER_FILE_BYPASS_EN
      if (wr_en && readReg1 == writeReg) begin
        readData1 = writeData;
        pending1  = 1'b0;
      end
      if (wr_en && readReg2 == writeReg) begin
        readData2 = writeData;
        pending2  = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against a behavioural model.
module tb_register_file;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          regWrite = 1'b0;
  logic [AW-1:0] writeReg = '0;
  logic [DW-1:0] writeData = '0;
  logic [AW-1:0] readReg1 = '0;
  logic [AW-1:0] readReg2 = '0;
  logic          claimValid = 1'b0;
  logic [AW-1:0] claimReg = '0;
  logic [DW-1:0] readData1, readData2;
  logic          pending1, pending2, ready;

  register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2), .claimValid(claimValid),
    .claimReg(claimReg), .pending1(pending1), .pending2(pending2), .ready(ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mregs [DEPTH];
  bit            mpend [DEPTH];
  bit            mrun;
  int            mcnt;

  task automatic model_reset();
    mrun = 1'b0;
    mcnt = 0;
    for (int i = 0; i < DEPTH; i++) mpend[i] = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input int idx);
    if (!mrun) return '0;
    if (BYP && regWrite && idx == int'(writeReg) && idx != 0) return writeData;
    if (idx == 0) return '0;
    return mregs[idx];
  endfunction

  function automatic logic exp_pd(input int idx);
    if (!mrun) return 1'b0;
    if (BYP && regWrite && idx == int'(writeReg) && idx != 0) return 1'b0;
    return mpend[idx];
  endfunction

  task automatic idle();
    regWrite   = 1'b0;
    claimValid = 1'b0;
  endtask

  // Advance the model by the effect of the current inputs, then one clock edge.
  task automatic cycle();
    if (rst_n) begin
      if (mrun) begin
        if (regWrite) begin
          if (writeReg != 0) mregs[writeReg] = writeData;
          mpend[writeReg] = 1'b0;
        end
        if (claimValid && claimReg != 0) mpend[claimReg] = 1'b1;
      end else begin
        mcnt++;
        if (mcnt == DEPTH) begin
          mrun = 1'b1;
          for (int i = 0; i < DEPTH; i++) mregs[i] = '0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Called right after rst_n release, between edges. Drives writes/claims on reg 3 early in INIT.
  task automatic check_sweep();
    for (int k = 1; k <= DEPTH + 2; k++) begin
      if (k < 20) begin
        regWrite = 1'b1; writeReg = 3; writeData = $urandom;
        claimValid = 1'b1; claimReg = 3; readReg1 = 3; readReg2 = AW'($urandom_range(1, DEPTH-1));
      end else idle();
      #1;
      if (k <= DEPTH) begin
        checks++;
        if (readData1 !== '0 || pending1 !== 1'b0 || readData2 !== '0 || pending2 !== 1'b0) begin
          failures++;
          $display("FAIL init_outputs k=%0d got rd1=%h p1=%b rd2=%h p2=%b exp all zero", k, readData1, pending1, readData2, pending2);
        end
      end
      cycle();
      checks++;
      if (ready !== (k >= DEPTH)) begin
        failures++;
        $display("FAIL ready_timing edge=%0d got=%b exp=%b", k, ready, (k >= DEPTH));
      end
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #23;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", ready);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_sweep();
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < DEPTH; i++) begin
      readReg1 = AW'(i);
      readReg2 = AW'(DEPTH - 1 - i);
      #1;
      checks++;
      if (readData1 !== '0 || readData2 !== '0) begin
        failures++;
        $display("FAIL swept_zero idx=%0d got rd1=%h rd2=%h exp 0", i, readData1, readData2);
      end
      checks++;
      if (pending1 !== 1'b0 || pending2 !== 1'b0) begin
        failures++;
        $display("FAIL swept_pending idx=%0d got p1=%b p2=%b exp 0", i, pending1, pending2);
      end
    end
  endtask

  task automatic test_dual_read();
    regWrite = 1'b1; writeReg = 5; writeData = 32'hDEADBEEF;
    cycle();
    idle();
    readReg1 = 5; readReg2 = 5;
    #1;
    checks++;
    if (readData1 !== 32'hDEADBEEF || readData2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL dual_read got rd1=%h rd2=%h exp deadbeef", readData1, readData2);
    end
  endtask

  task automatic test_zero_reg();
    regWrite = 1'b1; writeReg = 0; writeData = 32'h1234;
    claimValid = 1'b1; claimReg = 0; readReg1 = 0;
    cycle();
    idle();
    #1;
    checks++;
    if (readData1 !== '0 || pending1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg got rd1=%h p1=%b exp 0/0", readData1, pending1);
    end
  endtask

  task automatic test_pending();
    readReg1 = 7;
    claimValid = 1'b1; claimReg = 7;
    cycle();
    idle();
    #1;
    checks++;
    if (pending1 !== 1'b1) begin
      failures++;
      $display("FAIL pend_after_claim got=%b exp=1", pending1);
    end
    regWrite = 1'b1; writeReg = 7; writeData = 32'hA5;
    cycle();
    idle();
    #1;
    checks++;
    if (pending1 !== 1'b0 || readData1 !== 32'hA5) begin
      failures++;
      $display("FAIL pend_after_write got p1=%b rd1=%h exp 0/a5", pending1, readData1);
    end
    regWrite = 1'b1; writeReg = 7; writeData = 32'h5A;
    claimValid = 1'b1; claimReg = 7;
    cycle();
    idle();
    #1;
    checks++;
    if (pending1 !== 1'b1 || readData1 !== 32'h5A) begin
      failures++;
      $display("FAIL claim_wins got p1=%b rd1=%h exp 1/5a", pending1, readData1);
    end
  endtask

  task automatic test_bypass();
    regWrite = 1'b1; writeReg = 9; writeData = 32'h11;
    cycle();
    regWrite = 1'b1; writeReg = 9; writeData = 32'h55; readReg1 = 9;
    #1;
    checks++;
    if (readData1 !== (BYP ? 32'h55 : 32'h11)) begin
      failures++;
      $display("FAIL same_cycle_read got=%h exp=%h", readData1, (BYP ? 32'h55 : 32'h11));
    end
    cycle();
    idle();
    #1;
    checks++;
    if (readData1 !== 32'h55) begin
      failures++;
      $display("FAIL after_write_read got=%h exp=55", readData1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int hot;
      hot = $urandom_range(0, 3);
      regWrite   = ($urandom_range(0, 1) == 1);
      claimValid = ($urandom_range(0, 2) == 0);
      writeReg   = AW'(hot == 0 ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1));
      claimReg   = AW'(hot == 0 ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1));
      readReg1   = AW'(hot == 0 ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1));
      readReg2   = (hot == 1) ? readReg1 : AW'($urandom_range(0, DEPTH-1));
      writeData  = $urandom;
      #1;
      checks++;
      if (readData1 !== exp_rd(int'(readReg1)) || readData2 !== exp_rd(int'(readReg2))) begin
        failures++;
        $display("FAIL rand_read n=%0d r1=%0d got=%h exp=%h r2=%0d got=%h exp=%h", n, readReg1, readData1,
                 exp_rd(int'(readReg1)), readReg2, readData2, exp_rd(int'(readReg2)));
      end
      checks++;
      if (pending1 !== exp_pd(int'(readReg1)) || pending2 !== exp_pd(int'(readReg2))) begin
        failures++;
        $display("FAIL rand_pend n=%0d r1=%0d got=%b exp=%b r2=%0d got=%b exp=%b", n, readReg1, pending1,
                 exp_pd(int'(readReg1)), readReg2, pending2, exp_pd(int'(readReg2)));
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    claimValid = 1'b1; claimReg = 12;
    regWrite = 1'b1; writeReg = 12; writeData = 32'hCAFE;
    cycle();
    idle();
    readReg1 = 12; readReg2 = 12;
    #1;
    checks++;
    if (pending1 !== 1'b1 || readData1 !== 32'hCAFE) begin
      failures++;
      $display("FAIL pre_reset got p1=%b rd1=%h exp 1/cafe", pending1, readData1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || pending1 !== 1'b0 || readData1 !== '0) begin
      failures++;
      $display("FAIL async_reset got ready=%b p1=%b rd1=%h exp 0/0/0", ready, pending1, readData1);
    end
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    check_sweep();
    readReg1 = 12;
    #1;
    checks++;
    if (pending1 !== 1'b0 || readData1 !== '0) begin
      failures++;
      $display("FAIL post_sweep got p1=%b rd1=%h exp 0/0", pending1, readData1);
    end
  endtask

  task automatic test_reset_mid_init();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    rst_n = 1'b0;
    #2;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_init_reset got ready=%b exp=0", ready);
    end
    model_reset();
    rst_n = 1'b1;
    check_sweep();
    test_all_zero();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mregs[i] = '0;
    model_reset();
    test_reset();
    test_all_zero();
    test_dual_read();
    test_zero_reg();
    test_pending();
    test_bypass();
    test_random();
    test_reset_mid_run();
    test_random();
    test_reset_mid_init();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
